// File: rtl/rs_multicdb.sv
// Reservation station in front of a single ALU. Operands are captured from
// NUM_CDB broadcast channels. The oldest ready entry, tracked with an
// older-than matrix, is issued into a held valid/ready output register.
module rs_multicdb #(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_val1,
    input  logic [XLEN-1:0]          in_val2,
    input  logic [ROB_W-1:0]         in_tag1,
    input  logic [ROB_W-1:0]         in_tag2,
    input  logic                     in_need1,
    input  logic                     in_need2,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic                     in_funct7b,
    input  logic [ROB_W-1:0]         in_rob,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_val1,
    output logic [XLEN-1:0]          out_val2,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_imm,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_funct3,
    output logic                     out_funct7b,
    output logic [ROB_W-1:0]         out_rob,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  val1;
        logic [XLEN-1:0]  val2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7b;
        logic [ROB_W-1:0] rob;
    } iss_t;

    typedef struct packed {
        logic             need1;
        logic             need2;
        logic [ROB_W-1:0] tag1;
        logic [ROB_W-1:0] tag2;
        iss_t             op;
    } entry_t;

    entry_t           ent_q   [DEPTH];
    entry_t           ent_d   [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH];   // older_q[i][j]: entry i inserted before j
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             out_valid_q, out_valid_d;
    iss_t             out_q, out_d;

    logic [DEPTH-1:0] ready;
    logic [IW-1:0]    sel_idx, free_idx;
    logic             any_rdy, slot_free, disp, ins;

    // Lowest channel index wins: scan high to low so later hits overwrite.
    function automatic logic [XLEN:0] cdb_snoop(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       v,
        input logic [NUM_CDB*ROB_W-1:0] t,
        input logic [NUM_CDB*XLEN-1:0]  d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (v[c] && t[c*ROB_W +: ROB_W] == tag) r = {1'b1, d[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    assign in_ready    = (occ_q < CW'(DEPTH));
    assign occupancy   = occ_q;
    assign out_valid   = out_valid_q;
    assign out_val1    = out_q.val1;
    assign out_val2    = out_q.val2;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7b = out_q.funct7b;
    assign out_rob     = out_q.rob;

    // Oldest-ready select and lowest free slot, both from pre-edge state.
    always_comb begin
        logic sel_ok;
        ready    = '0;
        sel_idx  = '0;
        free_idx = '0;
        any_rdy  = 1'b0;
        sel_ok   = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ready[i] = vld_q[i] & ~ent_q[i].need1 & ~ent_q[i].need2;
        for (int i = 0; i < DEPTH; i++) begin
            sel_ok = ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && ready[j] && !older_q[i][j]) sel_ok = 1'b0;
            if (sel_ok) begin
                sel_idx = IW'(i);
                any_rdy = 1'b1;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld_q[i]) free_idx = IW'(i);
    end

    // Next state: wakeup, issue, insert with bypass, age update, flush.
    always_comb begin
        entry_t        ne;
        logic [XLEN:0] s1, s2;
        ent_d       = ent_q;
        older_d     = older_q;
        vld_d       = vld_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ne          = '0;
        s1          = '0;
        s2          = '0;

        slot_free = !out_valid_q || out_ready;
        disp      = slot_free && any_rdy;
        ins       = in_valid && in_ready && !rollback;

        for (int i = 0; i < DEPTH; i++) begin
            s1 = cdb_snoop(ent_q[i].tag1, cdb_valid, cdb_tag, cdb_val);
            s2 = cdb_snoop(ent_q[i].tag2, cdb_valid, cdb_tag, cdb_val);
            if (vld_q[i] && ent_q[i].need1 && s1[XLEN]) begin
                ent_d[i].need1    = 1'b0;
                ent_d[i].op.val1  = s1[XLEN-1:0];
            end
            if (vld_q[i] && ent_q[i].need2 && s2[XLEN]) begin
                ent_d[i].need2    = 1'b0;
                ent_d[i].op.val2  = s2[XLEN-1:0];
            end
        end

        if (disp) begin
            vld_d[sel_idx] = 1'b0;
            out_d          = ent_q[sel_idx].op;
            out_valid_d    = 1'b1;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end

        if (ins) begin
            ne.need1      = in_need1;
            ne.need2      = in_need2;
            ne.tag1       = in_tag1;
            ne.tag2       = in_tag2;
            ne.op.val1    = in_val1;
            ne.op.val2    = in_val2;
            ne.op.pc      = in_pc;
            ne.op.imm     = in_imm;
            ne.op.opcode  = in_opcode;
            ne.op.funct3  = in_funct3;
            ne.op.funct7b = in_funct7b;
            ne.op.rob     = in_rob;
            s1 = cdb_snoop(in_tag1, cdb_valid, cdb_tag, cdb_val);
            s2 = cdb_snoop(in_tag2, cdb_valid, cdb_tag, cdb_val);
            if (in_need1 && s1[XLEN]) begin
                ne.need1   = 1'b0;
                ne.op.val1 = s1[XLEN-1:0];
            end
            if (in_need2 && s2[XLEN]) begin
                ne.need2   = 1'b0;
                ne.op.val2 = s2[XLEN-1:0];
            end
            ent_d[free_idx] = ne;
            vld_d[free_idx] = 1'b1;
            // New entry is younger than everything currently valid; rewriting
            // its row and column makes stale bits of a recycled slot harmless.
            for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = vld_q[i];
            older_d[free_idx] = '0;
        end

        if (ins && !disp && occ_q != CW'(DEPTH)) occ_d = occ_q + 1'b1;
        else if (disp && !ins && occ_q != '0)    occ_d = occ_q - 1'b1;

        if (rollback) begin
            vld_d       = '0;
            out_valid_d = 1'b0;
            occ_d       = '0;
        end
    end

    // State registers; rdy = 0 freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (rdy) begin
            vld_q       <= vld_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ent_q       <= ent_d;
            older_q     <= older_d;
        end
    end
endmodule

// File: tb/tb_rs_multicdb.sv
// Bench for rs_multicdb: directed scenarios plus randomized traffic checked
// against an age-ordered queue model.
module tb_rs_multicdb;
    localparam int DEPTH = 16, XLEN = 32, ROB_W = 4, NUM_CDB = 2;

    logic        clk, rst, rdy, rollback, in_valid, in_ready;
    logic [31:0] in_val1, in_val2, in_pc, in_imm;
    logic [3:0]  in_tag1, in_tag2, in_rob;
    logic        in_need1, in_need2, in_funct7b;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic        out_valid, out_ready, out_funct7b;
    logic [31:0] out_val1, out_val2, out_pc, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [3:0]  out_rob;
    logic [4:0]  occupancy;

    rs_multicdb #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_val1(in_val1), .in_val2(in_val2), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_need1(in_need1), .in_need2(in_need2), .in_pc(in_pc), .in_imm(in_imm),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b(in_funct7b), .in_rob(in_rob),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val1(out_val1), .out_val2(out_val2), .out_pc(out_pc), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b(out_funct7b),
        .out_rob(out_rob), .occupancy(occupancy)
    );

    typedef struct packed {
        logic        n1, n2;
        logic [3:0]  t1, t2;
        logic [31:0] v1, v2, pc, imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  rob;
    } ment_t;

    ment_t mq[$];      // pending entries, oldest first
    logic  m_ov;
    ment_t m_out;
    int    n_chk = 0, n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    function automatic logic [32:0] m_snoop(input logic [3:0] tag);
        logic [32:0] r;
        r = '0;
        for (int c = 0; c < NUM_CDB; c++)
            if (!r[32] && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == tag)
                r = {1'b1, cdb_val[c*XLEN +: XLEN]};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_out = '0;
    endtask

    task automatic model_update();
        int          sz0, pick;
        logic [32:0] s;
        ment_t       e;
        if (!rdy) return;
        if (rollback) begin
            mq.delete();
            m_ov = 1'b0;
            return;
        end
        sz0  = mq.size();
        pick = -1;
        if (!m_ov || out_ready) begin
            for (int i = 0; i < mq.size(); i++)
                if (pick < 0 && !mq[i].n1 && !mq[i].n2) pick = i;
            if (pick >= 0) begin
                m_out = mq[pick];
                mq.delete(pick);
                m_ov = 1'b1;
            end else m_ov = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (e.n1) begin s = m_snoop(e.t1); if (s[32]) begin e.n1 = 1'b0; e.v1 = s[31:0]; end end
            if (e.n2) begin s = m_snoop(e.t2); if (s[32]) begin e.n2 = 1'b0; e.v2 = s[31:0]; end end
            mq[i] = e;
        end
        if (in_valid && sz0 < DEPTH) begin
            e = {in_need1, in_need2, in_tag1, in_tag2, in_val1, in_val2, in_pc, in_imm,
                 in_opcode, in_funct3, in_funct7b, in_rob};
            if (e.n1) begin s = m_snoop(e.t1); if (s[32]) begin e.n1 = 1'b0; e.v1 = s[31:0]; end end
            if (e.n2) begin s = m_snoop(e.t2); if (s[32]) begin e.n2 = 1'b0; e.v2 = s[31:0]; end end
            mq.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_val1 = '0; in_val2 = '0; in_tag1 = '0; in_tag2 = '0; in_need1 = 1'b0; in_need2 = 1'b0;
        in_pc = '0; in_imm = '0; in_opcode = '0; in_funct3 = '0; in_funct7b = 1'b0; in_rob = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic drive_ins(input logic [3:0] rob, input logic n1, input logic [3:0] t1,
                             input logic [31:0] v1, input logic n2, input logic [3:0] t2,
                             input logic [31:0] v2);
        in_valid = 1'b1; in_rob = rob;
        in_need1 = n1; in_tag1 = t1; in_val1 = v1;
        in_need2 = n2; in_tag2 = t2; in_val2 = v2;
        in_pc = $urandom; in_imm = $urandom; in_opcode = 7'($urandom);
        in_funct3 = 3'($urandom); in_funct7b = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3 rst = 1'b0;
        model_reset();
        #10;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (occupancy !== 5'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_chk++; if (out_rob !== 4'd0 || out_val1 !== 32'd0 || out_pc !== 32'd0)
            $display("FAIL reset_out_data got rob %0d val1 %h pc %h want zeros", out_rob, out_val1, out_pc); else n_pass++;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_in_order();
        logic [4:0] e_occ [5] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0};
        logic       e_ov  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_rob [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        idle();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive_ins(4'(k + 1), 1'b0, 4'd0, 32'h10 + k, 1'b0, 4'd0, 32'h20 + k);
            else in_valid = 1'b0;
            step();
            n_chk++; if (out_valid !== e_ov[k]) $display("FAIL inorder_ov cyc %0d got %b want %b", k, out_valid, e_ov[k]); else n_pass++;
            n_chk++; if (occupancy !== e_occ[k]) $display("FAIL inorder_occ cyc %0d got %0d want %0d", k, occupancy, e_occ[k]); else n_pass++;
            if (e_ov[k]) begin
                n_chk++; if (out_rob !== e_rob[k]) $display("FAIL inorder_rob cyc %0d got %0d want %0d", k, out_rob, e_rob[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_wakeup();
        idle();
        drive_ins(4'd5, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'h55);
        step();
        drive_ins(4'd6, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h67);
        step();
        n_chk++; if (occupancy !== 5'd2 || out_valid !== 1'b0) $display("FAIL wake_pre got occ %0d ov %b want 2 0", occupancy, out_valid); else n_pass++;
        in_valid = 1'b0;
        step();
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd6) $display("FAIL wake_young_first got ov %b rob %0d want 1 6", out_valid, out_rob); else n_pass++;
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_val = {32'hDEADBEEF, 32'h0};
        step();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL wake_latency got ov %b want 0", out_valid); else n_pass++;
        cdb_valid = '0;
        step();
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd5) $display("FAIL wake_issue got ov %b rob %0d want 1 5", out_valid, out_rob); else n_pass++;
        n_chk++; if (out_val1 !== 32'hDEADBEEF || out_val2 !== 32'h55) $display("FAIL wake_vals got %h %h want deadbeef 55", out_val1, out_val2); else n_pass++;
        step();
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 5'd0) $display("FAIL wake_drain got ov %b occ %0d want 0 0", out_valid, occupancy); else n_pass++;
    endtask

    task automatic test_bypass();
        idle();
        drive_ins(4'd9, 1'b0, 4'd0, 32'd123, 1'b1, 4'd3, 32'h0);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_val = {32'h0, 32'd42};
        step();
        idle();
        step();
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd9) $display("FAIL bypass_issue got ov %b rob %0d want 1 9", out_valid, out_rob); else n_pass++;
        n_chk++; if (out_val2 !== 32'd42 || out_val1 !== 32'd123) $display("FAIL bypass_vals got %0d %0d want 123 42", out_val1, out_val2); else n_pass++;
        step();
    endtask

    task automatic test_freeze();
        idle();
        drive_ins(4'd3, 1'b1, 4'd5, 32'h0, 1'b0, 4'd0, 32'h1);
        step();
        rdy = 1'b0;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_val = {32'h0, 32'h55};
        drive_ins(4'd4, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0, 32'h3);
        step();
        n_chk++; if (occupancy !== 5'd1 || out_valid !== 1'b0) $display("FAIL freeze_hold got occ %0d ov %b want 1 0", occupancy, out_valid); else n_pass++;
        idle();
        step();
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 5'd1) $display("FAIL freeze_cdb_ignored got ov %b occ %0d want 0 1", out_valid, occupancy); else n_pass++;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_val = {32'h0, 32'h77};
        step();
        cdb_valid = '0;
        step();
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd3 || out_val1 !== 32'h77)
            $display("FAIL freeze_release got ov %b rob %0d val1 %h want 1 3 77", out_valid, out_rob, out_val1); else n_pass++;
        step();
    endtask

    task automatic test_full();
        int          cnt;
        logic [142:0] snap;
        idle();
        out_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40 && in_ready; k++) begin
            drive_ins(4'(cnt), 1'b0, 4'd0, 32'(cnt), 1'b0, 4'd0, 32'(cnt));
            step();
            cnt++;
        end
        n_chk++; if (cnt != 17) $display("FAIL full_count got %0d inserts want 17", cnt); else n_pass++;
        n_chk++; if (occupancy !== 5'd16 || in_ready !== 1'b0) $display("FAIL full_state got occ %0d rdy %b want 16 0", occupancy, in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd0) $display("FAIL full_slot got ov %b rob %0d want 1 0", out_valid, out_rob); else n_pass++;
        snap = {out_val1, out_val2, out_pc, out_imm, out_opcode, out_funct3, out_funct7b, out_rob};
        drive_ins(4'hF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++; if ({out_val1, out_val2, out_pc, out_imm, out_opcode, out_funct3, out_funct7b, out_rob} !== snap || out_valid !== 1'b1)
                $display("FAIL full_hold cyc %0d output changed rob %0d", k, out_rob); else n_pass++;
            n_chk++; if (in_ready !== 1'b0 || occupancy !== 5'd16) $display("FAIL full_hold_rdy cyc %0d got rdy %b occ %0d want 0 16", k, in_ready, occupancy); else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_chk++; if (out_rob !== 4'd1 || occupancy !== 5'd15 || in_ready !== 1'b1)
            $display("FAIL full_release got rob %0d occ %0d rdy %b want 1 15 1", out_rob, occupancy, in_ready); else n_pass++;
        for (int k = 2; k <= 16; k++) begin
            step();
            n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'(k)) $display("FAIL full_drain got ov %b rob %0d want 1 %0d", out_valid, out_rob, k % 16); else n_pass++;
        end
        step();
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 5'd0) $display("FAIL full_empty got ov %b occ %0d want 0 0", out_valid, occupancy); else n_pass++;
    endtask

    task automatic test_age_order();
        int got[$];
        int exp_q[6] = '{2, 4, 1, 3, 5, 6};
        idle();
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b0; cdb_valid = '0;
            case (k)
                0: drive_ins(4'd1, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'h0);
                1: drive_ins(4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
                2: drive_ins(4'd3, 1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h0);
                3: drive_ins(4'd4, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
                4: drive_ins(4'd5, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'h0);
                5: drive_ins(4'd6, 1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h0);
                6: begin cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd1}; cdb_val = {32'h200, 32'h100}; end
                default: ;
            endcase
            step();
            if (out_valid) got.push_back(int'(out_rob));
        end
        n_chk++; if (got.size() != 6) $display("FAIL age_count got %0d issues want 6", got.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (i >= got.size() || got[i] != exp_q[i])
                $display("FAIL age_order pos %0d got %0d want %0d", i, (i < got.size()) ? got[i] : -1, exp_q[i]); else n_pass++;
        end
        idle();
    endtask

    task automatic test_rollback();
        idle();
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            drive_ins(4'(k), 1'b0, 4'd0, 32'(k), 1'b0, 4'd0, 32'(k));
            step();
        end
        n_chk++; if (occupancy !== 5'd6 || out_valid !== 1'b1) $display("FAIL rb_pre got occ %0d ov %b want 6 1", occupancy, out_valid); else n_pass++;
        rollback = 1'b1;
        drive_ins(4'd9, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'h9);
        step();
        n_chk++; if (occupancy !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rb_flush got occ %0d ov %b rdy %b want 0 0 1", occupancy, out_valid, in_ready); else n_pass++;
        idle();
        step();
        n_chk++; if (occupancy !== 5'd0 || out_valid !== 1'b0) $display("FAIL rb_dropped got occ %0d ov %b want 0 0", occupancy, out_valid); else n_pass++;
        drive_ins(4'd10, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hA);
        step();
        drive_ins(4'd11, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'hB);
        step();
        n_chk++; if (out_valid !== 1'b1 || out_rob !== 4'd10 || occupancy !== 5'd1)
            $display("FAIL rb_resume got ov %b rob %0d occ %0d want 1 10 1", out_valid, out_rob, occupancy); else n_pass++;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_chk++; if (out_valid !== 1'b0 || occupancy !== 5'd0 || out_rob !== 4'd0 || out_val1 !== 32'd0)
            $display("FAIL async_rst got ov %b occ %0d rob %0d val1 %h want zeros", out_valid, occupancy, out_rob, out_val1); else n_pass++;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_random();
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy       = ($urandom_range(9) != 0);
            rollback  = ($urandom_range(49) == 0);
            out_ready = ($urandom_range(9) < 7);
            if ($urandom_range(9) < 6)
                drive_ins(4'($urandom), 1'($urandom), 4'($urandom_range(7)), $urandom,
                          1'($urandom), 4'($urandom_range(7)), $urandom);
            else in_valid = 1'b0;
            cdb_valid = 2'($urandom);
            cdb_tag   = {4'($urandom_range(7)), 4'($urandom_range(7))};
            cdb_val   = {$urandom, $urandom};
            step();
            n_chk++; if (out_valid !== m_ov) $display("FAIL rnd_ov cyc %0d got %b want %b", cyc, out_valid, m_ov); else n_pass++;
            n_chk++; if (occupancy !== 5'(mq.size())) $display("FAIL rnd_occ cyc %0d got %0d want %0d", cyc, occupancy, mq.size()); else n_pass++;
            n_chk++; if (in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_in_ready cyc %0d got %b", cyc, in_ready); else n_pass++;
            if (m_ov) begin
                n_chk++;
                if ({out_val1, out_val2, out_pc, out_imm, out_opcode, out_funct3, out_funct7b, out_rob} !==
                    {m_out.v1, m_out.v2, m_out.pc, m_out.imm, m_out.op, m_out.f3, m_out.f7, m_out.rob})
                    $display("FAIL rnd_data cyc %0d got rob %0d v1 %h v2 %h want rob %0d v1 %h v2 %h",
                             cyc, out_rob, out_val1, out_val2, m_out.rob, m_out.v1, m_out.v2);
                else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wakeup();
        test_bypass();
        test_freeze();
        test_full();
        test_age_order();
        test_rollback();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
